fleet_placer_rnd: RTL and testbench
===================================

Name: fleet_placer_rnd

Overview:
- Parametrised successor of the CPU ship-insertion FSM: places a full configurable fleet on a BOARD_N x BOARD_N board using random direction, orientation and coordinates.
- Validates each candidate with the external placement validator through a req/ack handshake, and commits accepted ships with a one-cycle write pulse.
- Bounds retries per ship and reports done or fail.
- Sits between the LFSR random source and the validator/board memory. Drives the game controller's start-of-play via done.

Parameters:
BOARD_N, 10, board side length; legal coordinates are 0..BOARD_N-1
COORD_W, 4, coordinate/random-position width; requires BOARD_N <= 2**COORD_W <= 2*BOARD_N
NUM_TYPES, 5, number of ship types (type 0 placed first)
TYPE_W, 3, ship_type width; 2**TYPE_W >= NUM_TYPES
COUNT_W, 3, width of each per-type ship count
FLEET_CFG, {3'd1,3'd1,3'd2,3'd2,3'd5}, packed NUM_TYPES*COUNT_W counts; type i at bits [i*COUNT_W +: COUNT_W] (default: 5 submarines, 2 cruisers, 2 seaplanes, 1 battleship, 1 carrier)
MAX_RETRY, 31, conflicting attempts tolerated per ship before fail
RETRY_W, 5, retry counter width; holds MAX_RETRY
PLAYER_ID, 0, value driven on player (0 = CPU)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin placing the fleet; sampled in IDLE, DONE, FAIL
rnd_dir  in  1  random direction (0 horizontal, 1 vertical)
rnd_orient  in  2  random orientation (0 N, 1 S, 2 E, 3 W)
rnd_pos  in  COORD_W  random coordinate source
val_ack  in  1  validator result valid
val_conflict  in  1  1 = candidate conflicts; qualified by val_ack
val_req  out  1  candidate valid, request validation
x, y  out  COORD_W  candidate/committed coordinates
dir  out  1  candidate direction
orient  out  2  candidate orientation
ship_type  out  TYPE_W  type being placed
player  out  1  constant PLAYER_ID
wr_en  out  1  one-cycle commit strobe to board memory
busy  out  1  high outside IDLE/DONE/FAIL
done  out  1  fleet fully placed; held until start or reset
fail  out  1  retry budget exhausted; held until start or reset
placed  out  8  total ships committed since last start

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0 except player = PLAYER_ID. Internal type, count and retry counters are 0.
- States: IDLE, SEL_TYPE, PICK_DIR, PICK_X, PICK_Y, VALIDATE, COMMIT, DONE, FAIL.
- IDLE/DONE/FAIL + start=1: clear placed, done, fail, type index and counters; go to SEL_TYPE. start in any other state is ignored.
- SEL_TYPE:
  - Skip types whose FLEET_CFG count is 0; a run of zero-count types may advance one type per cycle.
  - When the type index reaches NUM_TYPES, go to DONE (done=1 next cycle).
  - Otherwise load ship_type, clear retry, go to PICK_DIR.
- PICK_DIR: latch rnd_dir into dir and rnd_orient into orient.
- PICK_X: latch rnd_pos into x. PICK_Y: latch rnd_pos into y.
- Coordinate fold applies to both PICK_X and PICK_Y: if rnd_pos >= BOARD_N, latch rnd_pos - BOARD_N; never output an illegal coordinate.
- VALIDATE: val_req=1 with x/y/dir/orient/ship_type stable. Stay until val_ack=1; ack in the first VALIDATE cycle is legal. val_req drops the cycle after ack.
  - ack with conflict=0: go to COMMIT.
  - ack with conflict=1 and retry < MAX_RETRY: retry+1, back to PICK_DIR (all fields re-drawn).
  - ack with conflict=1 and retry == MAX_RETRY: go to FAIL (fail=1, busy=0).
- COMMIT:
  - wr_en=1 for exactly one cycle with the accepted fields still on x/y/dir/orient/ship_type; placed+1.
  - If the ship count within the type reaches its FLEET_CFG value, advance the type index and go to SEL_TYPE; else go to PICK_DIR with retry cleared.
- Latency: minimum 5 cycles per placed ship (PICK_DIR, PICK_X, PICK_Y, VALIDATE, COMMIT), plus 1 SEL_TYPE cycle per type. The default fleet places 11 ships.
- Reset mid-operation: immediate abort. wr_en and val_req drop asynchronously; no partial commit.
- The validator holds val_ack low while no request is pending; an ack outside VALIDATE is ignored.

Decomposition:
- Shared package battleship_pkg: orientation encodings (N/S/E/W), direction constants, ship-type codes 0..4, default FLEET_CFG, PLAYER_CPU/PLAYER_HUMAN.
- One natural sub-module: coord_fold. Combinational rnd_pos -> legal coordinate; parametrised by BOARD_N and COORD_W; instantiated once and shared by PICK_X/PICK_Y.

Test Plan:
- Default parameters, start pulse, validator acks every request same cycle with conflict=0: wr_en fires 11 times, ship_type sequence 0,0,0,0,0,1,1,2,2,3,4, done=1, placed=11, roughly 60 cycles.
- rnd_pos stuck at 4'd13 with BOARD_N=10: every committed x=3 and y=3; never a value >= 10.
- Validator returns conflict=1 three times for the first ship, then 0: exactly one wr_en for ship 0, retry counter reaches 3, then the fleet completes normally.
- Conflict=1 always, MAX_RETRY=31: 32 val_req/ack transactions, then fail=1, busy=0, wr_en never asserted, placed=0.
- FLEET_CFG with type 2 count 0: no wr_en with ship_type=2; done asserted with placed=9.
- reset driven low while in VALIDATE with val_ack delayed 4 cycles: val_req and busy drop immediately; after release, state is IDLE and no wr_en occurs until a new start.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared encodings for the battleship ship placers: orientations, directions,
// ship-type codes, default fleet, player ids and the placer state type.
package battleship_pkg;

  localparam logic [1:0] ORIENT_N = 2'd0;
  localparam logic [1:0] ORIENT_S = 2'd1;
  localparam logic [1:0] ORIENT_E = 2'd2;
  localparam logic [1:0] ORIENT_W = 2'd3;

  localparam logic DIR_HORIZ = 1'b0;
  localparam logic DIR_VERT  = 1'b1;

  localparam logic [2:0] SHIP_SUBMARINE  = 3'd0;
  localparam logic [2:0] SHIP_CRUISER    = 3'd1;
  localparam logic [2:0] SHIP_SEAPLANE   = 3'd2;
  localparam logic [2:0] SHIP_BATTLESHIP = 3'd3;
  localparam logic [2:0] SHIP_CARRIER    = 3'd4;

  // Type 0 in the low bits: 5 submarines, 2 cruisers, 2 seaplanes, 1 battleship, 1 carrier
  localparam logic [14:0] FLEET_CFG_DEFAULT = {3'd1, 3'd1, 3'd2, 3'd2, 3'd5};

  localparam logic PLAYER_CPU   = 1'b0;
  localparam logic PLAYER_HUMAN = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL_TYPE,
    ST_PICK_DIR,
    ST_PICK_X,
    ST_PICK_Y,
    ST_VALIDATE,
    ST_COMMIT,
    ST_DONE,
    ST_FAIL
  } place_state_t;

endpackage

// File: rtl/fleet_placer_rnd_coord_fold.sv
// Folds a random value into a legal board coordinate by subtracting BOARD_N
// once; valid because the random range is below 2*BOARD_N.
module coord_fold #(
  parameter int BOARD_N = 10,
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] rnd_pos,
  output logic [COORD_W-1:0] coord
);

  // One extra bit so BOARD_N == 2**COORD_W still compares correctly
  localparam logic [COORD_W:0] BN = (COORD_W+1)'(BOARD_N);

  logic [COORD_W:0] wide_pos;

  assign wide_pos = {1'b0, rnd_pos};
  assign coord    = (wide_pos >= BN) ? (rnd_pos - BN[COORD_W-1:0]) : rnd_pos;

endmodule

// File: rtl/fleet_placer_rnd.sv
// Random fleet placer: draws direction/orientation/coordinates per ship, asks the
// external validator, commits accepted ships and bounds retries per ship.
module fleet_placer_rnd
  import battleship_pkg::*;
#(
  parameter int BOARD_N   = 10,
  parameter int COORD_W   = 4,
  parameter int NUM_TYPES = 5,
  parameter int TYPE_W    = 3,
  parameter int COUNT_W   = 3,
  parameter logic [NUM_TYPES*COUNT_W-1:0] FLEET_CFG = FLEET_CFG_DEFAULT,
  parameter int MAX_RETRY = 31,
  parameter int RETRY_W   = 5,
  parameter logic PLAYER_ID = PLAYER_CPU
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               rnd_dir,
  input  logic [1:0]         rnd_orient,
  input  logic [COORD_W-1:0] rnd_pos,
  input  logic               val_ack,
  input  logic               val_conflict,
  output logic               val_req,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               dir,
  output logic [1:0]         orient,
  output logic [TYPE_W-1:0]  ship_type,
  output logic               player,
  output logic               wr_en,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [7:0]         placed
);

  // Index needs to reach NUM_TYPES itself to signal the end of the fleet
  localparam int IDX_W = TYPE_W + 1;

  place_state_t       state;
  logic [IDX_W-1:0]   type_idx;
  logic [COUNT_W-1:0] ship_cnt;
  logic [RETRY_W-1:0] retry;
  logic [COORD_W-1:0] coord;

  function automatic logic [COUNT_W-1:0] cfg_count(input logic [IDX_W-1:0] idx);
    cfg_count = '0;
    for (int i = 0; i < NUM_TYPES; i++)
      if (idx == IDX_W'(i)) cfg_count = FLEET_CFG[i*COUNT_W +: COUNT_W];
  endfunction

  coord_fold #(
    .BOARD_N (BOARD_N),
    .COORD_W (COORD_W)
  ) u_coord_fold (
    .rnd_pos (rnd_pos),
    .coord   (coord)
  );

  assign player = PLAYER_ID;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      type_idx  <= '0;
      ship_cnt  <= '0;
      retry     <= '0;
      val_req   <= 1'b0;
      x         <= '0;
      y         <= '0;
      dir       <= 1'b0;
      orient    <= 2'd0;
      ship_type <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      placed    <= 8'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            placed   <= 8'd0;
            done     <= 1'b0;
            fail     <= 1'b0;
            type_idx <= '0;
            ship_cnt <= '0;
            retry    <= '0;
            busy     <= 1'b1;
            state    <= ST_SEL_TYPE;
          end
        end
        ST_SEL_TYPE: begin
          if (type_idx == IDX_W'(NUM_TYPES)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (cfg_count(type_idx) == '0) begin
            type_idx <= type_idx + 1'b1;
          end else begin
            ship_type <= type_idx[TYPE_W-1:0];
            retry     <= '0;
            state     <= ST_PICK_DIR;
          end
        end
        ST_PICK_DIR: begin
          dir    <= rnd_dir;
          orient <= rnd_orient;
          state  <= ST_PICK_X;
        end
        ST_PICK_X: begin
          x     <= coord;
          state <= ST_PICK_Y;
        end
        ST_PICK_Y: begin
          y       <= coord;
          val_req <= 1'b1;
          state   <= ST_VALIDATE;
        end
        ST_VALIDATE: begin
          if (val_ack) begin
            val_req <= 1'b0;
            if (!val_conflict) begin
              wr_en <= 1'b1;
              state <= ST_COMMIT;
            end else if (retry == RETRY_W'(MAX_RETRY)) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FAIL;
            end else begin
              retry <= retry + 1'b1;
              state <= ST_PICK_DIR;
            end
          end
        end
        ST_COMMIT: begin
          placed <= placed + 8'd1;
          if ((ship_cnt + 1'b1) == cfg_count(type_idx)) begin
            ship_cnt <= '0;
            type_idx <= type_idx + 1'b1;
            state    <= ST_SEL_TYPE;
          end else begin
            ship_cnt <= ship_cnt + 1'b1;
            retry    <= '0;
            state    <= ST_PICK_DIR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fleet_placer_rnd.sv
// Scoreboard bench for fleet_placer_rnd: expected commits are queued at start
// and compared on every wr_en strobe.
module tb_fleet_placer_rnd;

  typedef struct packed {
    logic [2:0] t;
    logic [3:0] x;
    logic [3:0] y;
    logic       d;
    logic [1:0] o;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start, start_z;
  logic rnd_dir;
  logic [1:0] rnd_orient;
  logic [3:0] rnd_pos;
  logic val_ack, val_conflict;
  logic val_req, dir, player, wr_en, busy, done, fail;
  logic [3:0] x, y;
  logic [1:0] orient;
  logic [2:0] ship_type;
  logic [7:0] placed;

  logic val_req_z, dir_z, player_z, wr_en_z, busy_z, done_z, fail_z;
  logic [3:0] x_z, y_z;
  logic [1:0] orient_z;
  logic [2:0] ship_type_z;
  logic [7:0] placed_z;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int wr_cnt_z = 0;
  int ack_cnt = 0;
  int wait_cnt = 0;
  int ack_delay = 0;
  int n_conflict = 0;
  bit conflict_always = 1'b0;
  exp_t q_main[$];
  exp_t q_z[$];

  localparam logic [14:0] CFG_DEF  = {3'd1, 3'd1, 3'd2, 3'd2, 3'd5};
  localparam logic [14:0] CFG_ZERO = {3'd1, 3'd1, 3'd0, 3'd2, 3'd5};

  always #5 clk = ~clk;

  fleet_placer_rnd dut (
    .clk(clk), .reset(reset), .start(start), .rnd_dir(rnd_dir),
    .rnd_orient(rnd_orient), .rnd_pos(rnd_pos), .val_ack(val_ack),
    .val_conflict(val_conflict), .val_req(val_req), .x(x), .y(y), .dir(dir),
    .orient(orient), .ship_type(ship_type), .player(player), .wr_en(wr_en),
    .busy(busy), .done(done), .fail(fail), .placed(placed)
  );

  fleet_placer_rnd #(.FLEET_CFG(CFG_ZERO)) dut_z (
    .clk(clk), .reset(reset), .start(start_z), .rnd_dir(rnd_dir),
    .rnd_orient(rnd_orient), .rnd_pos(rnd_pos), .val_ack(val_req_z),
    .val_conflict(1'b0), .val_req(val_req_z), .x(x_z), .y(y_z), .dir(dir_z),
    .orient(orient_z), .ship_type(ship_type_z), .player(player_z), .wr_en(wr_en_z),
    .busy(busy_z), .done(done_z), .fail(fail_z), .placed(placed_z)
  );

  // Validator model: acks after ack_delay request cycles, conflicts on demand
  assign val_ack      = val_req && (wait_cnt >= ack_delay);
  assign val_conflict = conflict_always || (ack_cnt < n_conflict);

  always @(posedge clk) begin
    if (!val_req || val_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (start) ack_cnt <= 0;
    else if (val_req && val_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (q_main.size() == 0) check("extra_wr", 32'd1, 32'd0);
      else check("commit", 32'({ship_type, x, y, dir, orient}), 32'(q_main.pop_front()));
    end
    if (wr_en_z) begin
      wr_cnt_z++;
      if (q_z.size() == 0) check("extra_wr_z", 32'd1, 32'd0);
      else check("commit_z", 32'({ship_type_z, x_z, y_z, dir_z, orient_z}), 32'(q_z.pop_front()));
    end
  end

  function automatic logic [3:0] fold(input logic [3:0] p);
    return (p >= 4'd10) ? p - 4'd10 : p;
  endfunction

  task automatic push_fleet(input bit z, input logic [14:0] cfg, input logic [3:0] pos,
                            input logic d, input logic [1:0] o);
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < int'(cfg[t*3 +: 3]); k++) begin
        e = '{t: 3'(t), x: fold(pos), y: fold(pos), d: d, o: o};
        if (z) q_z.push_back(e);
        else q_main.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input bit z);
    @(negedge clk);
    if (z) start_z = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_z = 1'b0;
  endtask

  task automatic wait_end(input bit z, output int cyc);
    cyc = 0;
    while (!(z ? (done_z || fail_z) : (done || fail)) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int wr_before;
    reset = 1'b0; start = 1'b0; start_z = 1'b0;
    rnd_dir = 1'b0; rnd_orient = 2'd0; rnd_pos = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_val_req", 32'(val_req), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_placed", 32'(placed), 32'd0);
    check("rst_xy", 32'({x, y}), 32'd0);
    check("rst_type", 32'(ship_type), 32'd0);
    check("rst_player", 32'(player), 32'd0);

    // Plain run: immediate acks, no conflicts
    rnd_pos = 4'd7; rnd_dir = 1'b1; rnd_orient = 2'd2;
    push_fleet(1'b0, CFG_DEF, rnd_pos, rnd_dir, rnd_orient);
    pulse_start(1'b0);
    wait_end(1'b0, cyc);
    check("t1_latency", 32'(cyc), 32'd61);
    check("t1_done", 32'({done, fail, busy}), 32'b100);
    check("t1_placed", 32'(placed), 32'd11);
    check("t1_queue_empty", 32'(q_main.size()), 32'd0);

    // Out-of-range coordinate folds to a legal one
    rnd_pos = 4'd13; rnd_dir = 1'b0; rnd_orient = 2'd3;
    push_fleet(1'b0, CFG_DEF, rnd_pos, rnd_dir, rnd_orient);
    pulse_start(1'b0);
    wait_end(1'b0, cyc);
    check("t2_placed", 32'(placed), 32'd11);
    check("t2_queue_empty", 32'(q_main.size()), 32'd0);

    // Three conflicts on the first ship, fold boundary rnd_pos == BOARD_N
    rnd_pos = 4'd10; rnd_dir = 1'b1; rnd_orient = 2'd1;
    n_conflict = 3;
    push_fleet(1'b0, CFG_DEF, rnd_pos, rnd_dir, rnd_orient);
    pulse_start(1'b0);
    wait_end(1'b0, cyc);
    check("t3_latency", 32'(cyc), 32'd73);
    check("t3_acks", 32'(ack_cnt), 32'd14);
    check("t3_done", 32'({done, fail, busy}), 32'b100);
    check("t3_placed", 32'(placed), 32'd11);
    check("t3_queue_empty", 32'(q_main.size()), 32'd0);

    // Every candidate conflicts: retry budget exhausted
    n_conflict = 0; conflict_always = 1'b1;
    wr_before = wr_cnt;
    pulse_start(1'b0);
    wait_end(1'b0, cyc);
    check("t4_acks", 32'(ack_cnt), 32'd32);
    check("t4_flags", 32'({done, fail, busy}), 32'b010);
    check("t4_placed", 32'(placed), 32'd0);
    check("t4_no_wr", 32'(wr_cnt - wr_before), 32'd0);
    conflict_always = 1'b0;

    // Fleet with zero seaplanes
    rnd_pos = 4'd9; rnd_dir = 1'b1; rnd_orient = 2'd0;
    push_fleet(1'b1, CFG_ZERO, rnd_pos, rnd_dir, rnd_orient);
    pulse_start(1'b1);
    wait_end(1'b1, cyc);
    check("t5_done", 32'({done_z, fail_z, busy_z}), 32'b100);
    check("t5_placed", 32'(placed_z), 32'd9);
    check("t5_wr_count", 32'(wr_cnt_z), 32'd9);
    check("t5_queue_empty", 32'(q_z.size()), 32'd0);

    // Reset while waiting for a slow validator
    ack_delay = 4;
    wr_before = wr_cnt;
    pulse_start(1'b0);
    cyc = 0;
    while (!val_req && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_reached_validate", 32'(val_req), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_async_val_req", 32'(val_req), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_idle_flags", 32'({val_req, busy, done, fail}), 32'd0);
    check("t6_no_wr", 32'(wr_cnt - wr_before), 32'd0);
    check("t6_placed", 32'(placed), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
